fpmul_ctrl_fsm: RTL and testbench
=================================

// Module: fpmul_ctrl_fsm
// PURPOSE
//  Parametrised control FSM for the FP multiplier datapath. Sequences operand
//  load -> multiplier start -> wait for completion.
//  - Accepts work on a valid/ready handshake.
//  - Monitors N_UNITS done sources in ANY or ALL completion mode.
//  - Bounds the wait with a timeout; supports synchronous abort.
//  - Presents completion/timeout status on an output valid/ready handshake.
// PARAMETERS
//  N_UNITS     2    number of multiplier done inputs (>=1)
//  DONE_MODE   0    0: complete when any unit done; 1: complete when all units done
//  LOAD_CYCLES 1    cycles load_en is held in LOAD (>=1)
//  CNT_W       16   width of load/timeout counters
//  TIMEOUT     256  max WAIT cycles before timeout (1..2^CNT_W-1)
// PORTS
//  clk           in   1        single clock, all logic on rising edge
//  rst_n         in   1        synchronous reset, active-low
//  in_valid      in   1        request to start an operation
//  in_ready      out  1        FSM can accept a request
//  abort         in   1        synchronous abort, returns FSM to IDLE
//  mul_done      in   N_UNITS  per-unit done pulses/levels from multipliers
//  load_en       out  1        operand register load enable
//  mul_start     out  1        one-cycle start pulse to multiplier(s)
//  out_valid     out  1        result status available
//  out_ready     in   1        consumer accepts status
//  out_unit_mask out  N_UNITS  units that reported done this operation
//  timeout_err   out  1        status is a timeout, not a completion
//  busy          out  1        state != IDLE
//  state         out  3        current state encoding (debug)
// BEHAVIOUR
//  States: IDLE=0 LOAD=1 ISSUE=2 WAIT=3 DONE=4 TOUT=5; codes 6,7 -> IDLE next cycle.
//  Reset (rst_n=0 at edge): state=IDLE, counters=0, done_seen=0.
//   - in_ready is forced 0 while rst_n=0; all other outputs 0.
//  Priority: reset > abort > normal transitions.
//   - abort in any non-IDLE state -> IDLE next cycle; clears counters and done_seen.
//   - in_ready = (state==IDLE) && !abort && rst_n.
//  IDLE: in_valid&&in_ready -> LOAD (accept edge = cycle 0).
//  LOAD: load_en=1; cnt counts 0..LOAD_CYCLES-1 -> ISSUE.
//   - load_en high for exactly LOAD_CYCLES cycles.
//  ISSUE: mul_start=1 for one cycle; clears done_seen and cnt -> WAIT.
//  WAIT: done_seen <= done_seen | mul_done each cycle; cnt increments.
//   - hit = DONE_MODE ? &(done_seen|mul_done) : |(done_seen|mul_done).
//   - hit -> DONE; else cnt==TIMEOUT-1 -> TOUT; else stay.
//   - hit and timeout in same cycle: hit wins (DONE, timeout_err=0).
//  DONE: out_valid=1, timeout_err=0, out_unit_mask=done_seen (stable while held).
//  TOUT: out_valid=1, timeout_err=1, out_unit_mask=partial done_seen.
//  DONE/TOUT: hold until out_ready=1 -> IDLE next cycle; no new request accepted
//   until back in IDLE.
//  mul_done outside WAIT (including the ISSUE cycle) is ignored; no stale carry-over.
//  Outputs are decoded from registered state/latches (Moore); no comb path
//   mul_done -> out_*.
//  Latency (no abort): mul_start at cycle LOAD_CYCLES+1; WAIT starts LOAD_CYCLES+2.
//   - hit seen in WAIT cycle k -> out_valid from cycle k+1.
// TESTING
//  1 rst_n=0 3 cycles, in_valid=1 -> state=0, in_ready=0, all outs 0;
//    release -> in_ready=1.
//  2 N=2, MODE=0, LOAD=1: accept c0, load_en c1, mul_start c2, mul_done=2'b10 c5
//    -> out_valid c6, mask=10; out_ready c8 -> IDLE c9.
//  3 MODE=1: mul_done=01 c4, =10 c7 (pulses) -> out_valid c8, mask=11, timeout_err=0.
//  4 TIMEOUT=4, no mul_done -> TOUT after 4 WAIT cycles: out_valid=1,
//    timeout_err=1, mask=00.
//  5 TIMEOUT=4, mul_done=01 on 4th WAIT cycle -> DONE, timeout_err=0 (hit wins).
//  6 abort in WAIT -> IDLE next cycle; mul_done=11 in IDLE ignored; next op mask
//    holds only new dones.

Source files
------------

// File: rtl/fpmul_ctrl_fsm.sv
// Control sequencer for the FP multiplier datapath: load operands, pulse start,
// wait for ANY/ALL unit completion under a timeout, then report status.
module fpmul_ctrl_fsm #(
    parameter int N_UNITS     = 2,
    parameter int DONE_MODE   = 0,
    parameter int LOAD_CYCLES = 1,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               abort,
    input  logic [N_UNITS-1:0] mul_done,
    output logic               load_en,
    output logic               mul_start,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_UNITS-1:0] out_unit_mask,
    output logic               timeout_err,
    output logic               busy,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4,
        TOUT  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_UNITS-1:0] seen_q, seen_d;
    logic [N_UNITS-1:0] seen_now;
    logic               hit;

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and held status stays stable.
    assign in_ready = (state_q == IDLE) && !abort && rst_n;

    assign seen_now = seen_q | mul_done;
    assign hit      = (DONE_MODE != 0) ? (&seen_now) : (|seen_now);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seen_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
            seen_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end
                end
                LOAD: begin
                    if (cnt_q == LOAD_LAST) begin
                        state_d = ISSUE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ISSUE: begin
                    // Dones arriving alongside the start pulse belong to no operation.
                    state_d = WAIT;
                    cnt_d   = '0;
                    seen_d  = '0;
                end
                WAIT: begin
                    seen_d = seen_now;
                    cnt_d  = cnt_q + 1'b1;
                    if (hit) begin
                        state_d = DONE;
                    end else if (cnt_q == TOUT_LAST) begin
                        state_d = TOUT;
                    end
                end
                DONE, TOUT: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    seen_d  = '0;
                end
            endcase
        end
    end

    assign load_en       = (state_q == LOAD);
    assign mul_start     = (state_q == ISSUE);
    assign out_valid     = (state_q == DONE) || (state_q == TOUT);
    assign timeout_err   = (state_q == TOUT);
    assign out_unit_mask = out_valid ? seen_q : '0;
    assign busy          = (state_q != IDLE);
    assign state         = state_q;

endmodule

// File: tb/tb_fpmul_ctrl_fsm.sv
// Bench for fpmul_ctrl_fsm: two instances (ANY mode / ALL mode) checked every
// cycle against a cycle-count transaction model, plus directed literal checks.
module tb_fpmul_ctrl_fsm;

    localparam int N   = 2;
    localparam int L   = 1;
    localparam int TO0 = 4;
    localparam int TO1 = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       in_valid = '0;
    logic [1:0]       abort = '0;
    logic [1:0]       out_ready = '0;
    logic [N-1:0]     mul_done [2];
    logic [1:0]       in_ready, load_en, mul_start, out_valid, timeout_err, busy;
    logic [N-1:0]     mask [2];
    logic [2:0]       st [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model of each instance: accept-relative age, accumulated dones, pending result
    bit           m_active [2];
    int           m_age [2];
    logic [N-1:0] m_seen [2];
    int           m_res [2];
    logic [N-1:0] m_mask [2];
    logic [N:0]   exp_q0[$];
    logic [N:0]   exp_q1[$];

    always #5 clk = ~clk;

    fpmul_ctrl_fsm #(.N_UNITS(N), .DONE_MODE(0), .LOAD_CYCLES(L), .CNT_W(16), .TIMEOUT(TO0)) dut_any (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .abort(abort[0]), .mul_done(mul_done[0]), .load_en(load_en[0]),
        .mul_start(mul_start[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_unit_mask(mask[0]), .timeout_err(timeout_err[0]), .busy(busy[0]), .state(st[0])
    );

    fpmul_ctrl_fsm #(.N_UNITS(N), .DONE_MODE(1), .LOAD_CYCLES(L), .CNT_W(16), .TIMEOUT(TO1)) dut_all (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .abort(abort[1]), .mul_done(mul_done[1]), .load_en(load_en[1]),
        .mul_start(mul_start[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_unit_mask(mask[1]), .timeout_err(timeout_err[1]), .busy(busy[1]), .state(st[1])
    );

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int i);
        in_valid[i] = 1'b1;
        check("accept_ready", i, 32'(in_ready[i]), 32'd1);
        tick();
        in_valid[i] = 1'b0;
    endtask

    task automatic release_status(input int i);
        out_ready[i] = 1'b1;
        tick();
        out_ready[i] = 1'b0;
        check("back_idle", i, 32'(st[i]), 32'd0);
    endtask

    function automatic void clear_model(input int i);
        m_active[i] = 1'b0;
        m_age[i]    = 0;
        m_seen[i]   = '0;
        m_res[i]    = 0;
        m_mask[i]   = '0;
    endfunction

    // model update on each rising edge, from the inputs held during the cycle
    initial begin
        for (int i = 0; i < 2; i++) clear_model(i);
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    clear_model(i);
                end else if (abort[i] && (m_active[i] || m_res[i] != 0)) begin
                    if (m_res[i] != 0) begin
                        if (i == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
                    end
                    clear_model(i);
                end else if (m_res[i] != 0) begin
                    if (out_ready[i]) clear_model(i);
                end else if (m_active[i]) begin
                    if (m_age[i] >= L + 2) begin
                        int  w;
                        bit  hit;
                        w         = m_age[i] - (L + 2);
                        m_seen[i] = m_seen[i] | mul_done[i];
                        hit       = (i == 1) ? (m_seen[i] == '1) : (m_seen[i] != '0);
                        if (hit || w == ((i == 0) ? TO0 : TO1) - 1) begin
                            m_res[i]  = hit ? 1 : 2;
                            m_mask[i] = m_seen[i];
                            if (i == 0) exp_q0.push_back({!hit, m_seen[i]});
                            else        exp_q1.push_back({!hit, m_seen[i]});
                        end
                    end
                    m_age[i]++;
                end else if (in_valid[i] && !abort[i]) begin
                    m_active[i] = 1'b1;
                    m_age[i]    = 1;
                    m_seen[i]   = '0;
                end
            end
        end
    end

    // every-cycle comparison against the model, plus status scoreboard on handshake
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 2; i++) begin
                    int           e_st;
                    bit           e_ld, e_go, e_ov, e_te, e_bz, e_rdy;
                    logic [N-1:0] e_mk;
                    e_st = 0; e_ld = 0; e_go = 0; e_ov = 0; e_te = 0; e_bz = 0; e_mk = '0;
                    e_rdy = 0;
                    if (m_res[i] != 0) begin
                        e_st = (m_res[i] == 1) ? 4 : 5;
                        e_ov = 1; e_te = (m_res[i] == 2); e_mk = m_mask[i]; e_bz = 1;
                    end else if (m_active[i]) begin
                        e_bz = 1;
                        if (m_age[i] <= L) begin
                            e_st = 1; e_ld = 1;
                        end else if (m_age[i] == L + 1) begin
                            e_st = 2; e_go = 1;
                        end else begin
                            e_st = 3;
                        end
                    end else begin
                        e_rdy = rst_n && !abort[i];
                    end
                    check("state", i, 32'(st[i]), 32'(e_st));
                    check("in_ready", i, 32'(in_ready[i]), 32'(e_rdy));
                    check("load_en", i, 32'(load_en[i]), 32'(e_ld));
                    check("mul_start", i, 32'(mul_start[i]), 32'(e_go));
                    check("out_valid", i, 32'(out_valid[i]), 32'(e_ov));
                    check("timeout_err", i, 32'(timeout_err[i]), 32'(e_te));
                    check("mask", i, 32'(mask[i]), 32'(e_mk));
                    check("busy", i, 32'(busy[i]), 32'(e_bz));
                    if (out_valid[i] && out_ready[i] && rst_n && !abort[i]) begin
                        logic [N:0] exp;
                        int         depth;
                        depth = (i == 0) ? exp_q0.size() : exp_q1.size();
                        check("sb_depth", i, 32'(depth > 0), 32'd1);
                        if (depth > 0) begin
                            exp = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            check("sb_status", i, 32'({timeout_err[i], mask[i]}), 32'(exp));
                        end
                    end
                end
            end
        end
    end

    initial begin
        mul_done[0] = '0;
        mul_done[1] = '0;

        // reset held 3 cycles with requests pending
        in_valid = 2'b11;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            check("rst_state", i, 32'(st[i]), 32'd0);
            check("rst_ready", i, 32'(in_ready[i]), 32'd0);
            check("rst_outs", i, 32'({load_en[i], mul_start[i], out_valid[i], timeout_err[i], busy[i], mask[i]}), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check("rel_ready", 0, 32'(in_ready[0]), 32'd1);
        check("rel_ready", 1, 32'(in_ready[1]), 32'd1);
        in_valid = 2'b00;
        tick();

        // ANY mode: done from unit 1 in the third WAIT cycle
        accept(0);
        check("t2_load", 0, 32'(load_en[0]), 32'd1);
        tick();
        check("t2_start", 0, 32'(mul_start[0]), 32'd1);
        tick(); tick(); tick();
        mul_done[0] = 2'b10;
        check("t2_c5_valid", 0, 32'(out_valid[0]), 32'd0);
        tick();
        mul_done[0] = 2'b00;
        check("t2_c6_valid", 0, 32'(out_valid[0]), 32'd1);
        check("t2_c6_mask", 0, 32'(mask[0]), 32'h2);
        check("t2_c6_terr", 0, 32'(timeout_err[0]), 32'd0);
        in_valid[0] = 1'b1;
        check("t2_c6_noaccept", 0, 32'(in_ready[0]), 32'd0);
        tick();
        tick();
        in_valid[0] = 1'b0;
        check("t2_c8_hold", 0, 32'(out_valid[0]), 32'd1);
        release_status(0);
        check("t2_c9_ready", 0, 32'(in_ready[0]), 32'd1);

        // ALL mode: two separated single-unit pulses
        accept(1);
        tick(); tick(); tick();
        mul_done[1] = 2'b01;
        tick();
        mul_done[1] = 2'b00;
        tick(); tick();
        mul_done[1] = 2'b10;
        check("t3_c7_valid", 1, 32'(out_valid[1]), 32'd0);
        tick();
        mul_done[1] = 2'b00;
        check("t3_c8_valid", 1, 32'(out_valid[1]), 32'd1);
        check("t3_c8_mask", 1, 32'(mask[1]), 32'h3);
        check("t3_c8_terr", 1, 32'(timeout_err[1]), 32'd0);
        release_status(1);

        // timeout with a done during ISSUE that must be ignored
        accept(0);
        tick();
        mul_done[0] = 2'b11;
        tick();
        mul_done[0] = 2'b00;
        tick(); tick(); tick();
        check("t4_c6_valid", 0, 32'(out_valid[0]), 32'd0);
        tick();
        check("t4_c7_valid", 0, 32'(out_valid[0]), 32'd1);
        check("t4_c7_terr", 0, 32'(timeout_err[0]), 32'd1);
        check("t4_c7_mask", 0, 32'(mask[0]), 32'h0);
        release_status(0);

        // done on the final WAIT cycle beats the timeout
        accept(0);
        repeat (5) tick();
        mul_done[0] = 2'b01;
        tick();
        mul_done[0] = 2'b00;
        check("t5_valid", 0, 32'(out_valid[0]), 32'd1);
        check("t5_terr", 0, 32'(timeout_err[0]), 32'd0);
        check("t5_state", 0, 32'(st[0]), 32'd4);
        release_status(0);

        // abort in WAIT, dones while idle, then a fresh operation
        accept(0);
        repeat (3) tick();
        abort[0] = 1'b1;
        check("t6_abort_ready", 0, 32'(in_ready[0]), 32'd0);
        tick();
        abort[0] = 1'b0;
        check("t6_idle", 0, 32'(busy[0]), 32'd0);
        mul_done[0] = 2'b11;
        tick(); tick();
        mul_done[0] = 2'b00;
        accept(0);
        tick(); tick();
        mul_done[0] = 2'b10;
        tick();
        mul_done[0] = 2'b00;
        check("t6_mask", 0, 32'(mask[0]), 32'h2);
        release_status(0);

        // abort while status is held; abort in IDLE blocks acceptance
        accept(0);
        repeat (2) tick();
        mul_done[0] = 2'b01;
        tick();
        mul_done[0] = 2'b00;
        abort[0] = 1'b1;
        in_valid[0] = 1'b1;
        tick();
        check("t7_abort_done", 0, 32'(st[0]), 32'd0);
        tick();
        check("t7_no_accept", 0, 32'(busy[0]), 32'd0);
        abort[0] = 1'b0;
        in_valid[0] = 1'b0;
        tick();

        // ALL mode timeout with a partial mask
        accept(1);
        repeat (4) tick();
        mul_done[1] = 2'b01;
        tick();
        mul_done[1] = 2'b00;
        repeat (12) tick();
        check("t8_c18_valid", 1, 32'(out_valid[1]), 32'd0);
        tick();
        check("t8_c19_valid", 1, 32'(out_valid[1]), 32'd1);
        check("t8_c19_terr", 1, 32'(timeout_err[1]), 32'd1);
        check("t8_c19_mask", 1, 32'(mask[1]), 32'h1);
        release_status(1);

        tick(); tick();
        chk_en = 1'b0;
        check("sb_empty", 0, 32'(exp_q0.size()), 32'd0);
        check("sb_empty", 1, 32'(exp_q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
